// File: rtl/input_mem_loader.sv
// input_mem_loader: packs an input beat stream into memory words, writes them from address 0,
// then hands the finished image to the compute core and waits for it to finish.
module input_mem_loader #(
  parameter int IN_WIDTH    = 32,
  parameter int MEM_WIDTH   = 128,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 17
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DEPTH_WIDTH-1:0] load_depth,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [IN_WIDTH-1:0]    s_data,
  input  logic                   s_last,
  output logic                   mem_WE,
  output logic [ADDR_WIDTH-1:0]  mem_waddr,
  output logic [MEM_WIDTH-1:0]   mem_wdata,
  output logic                   new_image_pulse,
  input  logic                   compute_done,
  output logic                   busy,
  output logic                   frame_err
);
  localparam int BEATS = MEM_WIDTH / IN_WIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [DEPTH_WIDTH-1:0] MAX_DEPTH = DEPTH_WIDTH'(2 ** ADDR_WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, PULSE, WAIT} state_t;
  state_t                 state_q, state_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d, word_q, word_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [MEM_WIDTH-1:0]   pack_q, pack_d, packed_w, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic                   we_q, we_d, pulse_q, pulse_d, ferr_q, ferr_d, full, last_word;
  assign s_ready         = state_q == LOAD;
  assign busy            = state_q != IDLE;
  assign mem_WE          = we_q;
  assign mem_waddr       = waddr_q;
  assign mem_wdata       = wdata_q;
  assign new_image_pulse = pulse_q;
  assign frame_err       = ferr_q;
  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    word_d   = word_q;
    beat_d   = beat_q;
    pack_d   = pack_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    pulse_d  = 1'b0;
    ferr_d   = 1'b0;
    packed_w = pack_q;
    packed_w[int'(beat_q) * IN_WIDTH +: IN_WIDTH] = s_data;
    full      = beat_q == BW'(BEATS - 1);
    last_word = word_q + DEPTH_WIDTH'(1) == depth_q;
    if (state_q == IDLE && start && load_depth != '0) begin
      state_d = LOAD;
      depth_d = load_depth > MAX_DEPTH ? MAX_DEPTH : load_depth;
      word_d  = '0;
      beat_d  = '0;
      pack_d  = '0;
    end
    if (state_q == LOAD && s_valid) begin
      pack_d = packed_w;
      beat_d = beat_q + BW'(1);
      // pack is cleared after every write, so lanes above an early s_last stay zero
      if (full || s_last) begin
        we_d    = 1'b1;
        waddr_d = word_q[ADDR_WIDTH-1:0];
        wdata_d = packed_w;
        word_d  = word_q + DEPTH_WIDTH'(1);
        beat_d  = '0;
        pack_d  = '0;
        ferr_d  = s_last != (full && last_word);
        if (s_last || last_word) state_d = PULSE;
      end
    end
    if (state_q == PULSE) begin
      pulse_d = 1'b1;
      state_d = WAIT;
    end
    if (state_q == WAIT && compute_done) state_d = IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      word_q  <= '0;
      beat_q  <= '0;
      pack_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      pulse_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
      pack_q  <= pack_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      pulse_q <= pulse_d;
      ferr_q  <= ferr_d;
    end
  end
endmodule

// File: tb/tb_input_mem_loader.sv
// tb_input_mem_loader: directed image loads checked every cycle against a beat-count model,
// plus literal expectations on the captured memory writes.
module tb_input_mem_loader;
  localparam int IW = 32, MW = 128, AW = 4, DW = 5, B = MW / IW;
  logic          clock = 0, reset = 1, start = 0, s_valid = 0, s_last = 0, compute_done = 0;
  logic [DW-1:0] load_depth = '0;
  logic [IW-1:0] s_data = '0;
  logic          s_ready, mem_WE, new_image_pulse, busy, frame_err;
  logic [AW-1:0] mem_waddr;
  logic [MW-1:0] mem_wdata;
  int            n_cmp = 0, n_bad = 0, cyc = 0, pulse_cyc = -1, pulses = 0;
  logic [AW-1:0] log_addr[$];
  logic [MW-1:0] log_data[$];
  logic          log_ferr[$];
  int            log_cyc[$];
  // model: 0 idle, 1 loading, 2 final write cycle, 3 waiting for compute_done
  int            m_st = 0, m_beats = 0, m_depth = 0;
  logic [IW-1:0] lanes[B];
  logic          exp_we = 0, exp_pulse = 0, exp_ferr = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [MW-1:0] exp_data = '0;

  input_mem_loader #(.IN_WIDTH(IW), .MEM_WIDTH(MW), .ADDR_WIDTH(AW), .DEPTH_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .load_depth(load_depth),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_WE(mem_WE), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .new_image_pulse(new_image_pulse), .compute_done(compute_done),
    .busy(busy), .frame_err(frame_err));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      chk("rst_we", MW'(mem_WE), 0);
      chk("rst_waddr", MW'(mem_waddr), 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_pulse", MW'(new_image_pulse), 0);
      chk("rst_busy", MW'(busy), 0);
      chk("rst_ferr", MW'(frame_err), 0);
      chk("rst_ready", MW'(s_ready), 0);
      m_st = 0; exp_we = 0; exp_pulse = 0;
    end else begin
      chk("we", MW'(mem_WE), MW'(exp_we));
      if (exp_we) begin
        chk("waddr", MW'(mem_waddr), MW'(exp_addr));
        chk("wdata", mem_wdata, exp_data);
      end
      chk("ferr", MW'(frame_err), MW'(exp_we && exp_ferr));
      chk("pulse", MW'(new_image_pulse), MW'(exp_pulse));
      chk("ready", MW'(s_ready), MW'(m_st == 1));
      chk("busy", MW'(busy), MW'(m_st != 0));
      if (mem_WE) begin
        log_addr.push_back(mem_waddr); log_data.push_back(mem_wdata);
        log_ferr.push_back(frame_err); log_cyc.push_back(cyc);
      end
      if (new_image_pulse) begin pulse_cyc = cyc; pulses++; end
      exp_pulse = m_st == 2;
      exp_we = 0;
      case (m_st)
        0: if (start && load_depth != 0) begin
             m_st = 1; m_beats = 0;
             m_depth = int'(load_depth) > (1 << AW) ? (1 << AW) : int'(load_depth);
             for (int k = 0; k < B; k++) lanes[k] = '0;
           end
        1: if (s_valid) begin
             lanes[m_beats % B] = s_data;
             m_beats++;
             if (m_beats % B == 0 || s_last) begin
               exp_we = 1;
               exp_addr = AW'((m_beats - 1) / B);
               for (int k = 0; k < B; k++) begin exp_data[k*IW +: IW] = lanes[k]; lanes[k] = '0; end
               exp_ferr = s_last != (m_beats == m_depth * B);
               if (s_last || m_beats == m_depth * B) m_st = 2;
             end
           end
        2: m_st = 3;
        default: if (compute_done) m_st = 0;
      endcase
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic start_load(input logic [DW-1:0] d);
    start = 1; load_depth = d; step(); start = 0;
  endtask

  task automatic beat(input logic [IW-1:0] d, input logic l);
    logic ok = 0;
    int   n = 0;
    s_valid = 1; s_data = d; s_last = l;
    while (!ok && n < 20) begin @(negedge clock); ok = s_ready; @(posedge clock); #1; n++; end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL beat_timeout: s_ready 0 expected 1"); end
    s_valid = 0; s_last = 0;
  endtask

  task automatic wait_pulse();
    int p0 = pulses;
    for (int n = 0; n < 20 && pulses == p0; n++) step();
    chk("pulse_seen", MW'(pulses - p0), 1);
  endtask

  task automatic finish_image();
    compute_done = 1; step(); compute_done = 0; step();
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_ferr.delete(); log_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(3);
    chk("reset_busy", MW'(busy), 0);
    reset = 0;
    step();
    // image of two full words, s_last on the final beat
    start_load(2);
    for (int i = 0; i < 8; i++) beat(IW'(i), i == 7);
    wait_pulse();
    chk("t1_nwr", MW'(log_addr.size()), 2);
    chk("t1_a0", MW'(log_addr[0]), 0);
    chk("t1_d0", log_data[0], 128'h00000003_00000002_00000001_00000000);
    chk("t1_a1", MW'(log_addr[1]), 1);
    chk("t1_d1", log_data[1], 128'h00000007_00000006_00000005_00000004);
    chk("t1_ferr", MW'({log_ferr[0], log_ferr[1]}), 0);
    chk("t1_pulse_lat", MW'(pulse_cyc - log_cyc[1]), 1);
    finish_image();
    // early s_last on beat 5: second word zero-filled and flagged
    clear_log();
    start_load(2);
    for (int i = 0; i < 6; i++) beat(IW'(i), i == 5);
    wait_pulse();
    chk("t2_nwr", MW'(log_addr.size()), 2);
    chk("t2_d1", log_data[1], 128'h00000000_00000000_00000005_00000004);
    chk("t2_ferr", MW'({log_ferr[0], log_ferr[1]}), 1);
    chk("t2_pulse_lat", MW'(pulse_cyc - log_cyc[1]), 1);
    finish_image();
    // gapped stream, then start while waiting and a zero-depth start
    clear_log();
    start_load(1);
    for (int i = 0; i < 4; i++) begin beat(IW'(10 + i), i == 3); step(); end
    wait_pulse();
    chk("t3_d0", log_data[0], 128'h0000000d_0000000c_0000000b_0000000a);
    step(2);
    chk("t3_wait_busy", MW'(busy), 1);
    chk("t3_wait_ready", MW'(s_ready), 0);
    start_load(1);
    step(2);
    chk("t4_busy_held", MW'(busy), 1);
    finish_image();
    chk("t4_idle", MW'(busy), 0);
    start_load(0);
    step(2);
    chk("t4_depth0_busy", MW'(busy), 0);
    chk("t4_depth0_ready", MW'(s_ready), 0);
    // reset mid-load, then reload from address 0
    start_load(4);
    for (int i = 0; i < 6; i++) beat(IW'(i), 0);
    reset = 1;
    step();
    reset = 0;
    clear_log();
    step();
    start_load(1);
    for (int i = 0; i < 4; i++) beat(IW'(20 + i), i == 3);
    wait_pulse();
    chk("t5_a0", MW'(log_addr[0]), 0);
    chk("t5_d0", log_data[0], 128'h00000017_00000016_00000015_00000014);
    finish_image();
    // full address range, then an over-range depth that clamps to it
    for (int t = 0; t < 2; t++) begin
      clear_log();
      start_load(t == 0 ? 5'h10 : 5'h1F);
      for (int i = 0; i < 64; i++) beat(IW'(i), i == 63);
      wait_pulse();
      chk("t6_nwr", MW'(log_addr.size()), 16);
      chk("t6_last_addr", MW'(log_addr[15]), 15);
      chk("t6_last_data", log_data[15], 128'h0000003f_0000003e_0000003d_0000003c);
      chk("t6_ferr", MW'(log_ferr[15]), 0);
      finish_image();
    end
    // missing s_last on the final beat
    clear_log();
    start_load(1);
    for (int i = 0; i < 4; i++) beat(IW'(i), 0);
    wait_pulse();
    chk("t7_ferr", MW'(log_ferr[0]), 1);
    finish_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
